// File: rtl/seq_ab_pkg.sv
// ============================================================================
// Module   : seq_ab_pkg
// Purpose  : shared state encoding and limits for the a/b sequence driver
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package seq_ab_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_ab_state_t;

  localparam int DELAY_MAX = 15;

endpackage

`default_nettype wire

// File: rtl/seq_delay_line.sv
// ============================================================================
// Module   : seq_delay_line
// Purpose  : DEPTH-stage shift register; any_set covers every stage but the last
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_out,
  output logic any_set
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sr <= '0;
        else     r_sr <= d_in;
      end
      assign any_set = 1'b0;
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sr <= '0;
        else     r_sr <= {r_sr[DEPTH-2:0], d_in};
      end
      // The last stage is the one currently firing, so it no longer counts as pending.
      assign any_set = |r_sr[DEPTH-2:0];
    end
  endgenerate

  assign d_out = r_sr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/seq_ab_driver.sv
// ============================================================================
// Module   : seq_ab_driver
// Purpose  : a/b sequence transmitter; one `a` per accepted request, `b` DELAY cycles later
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_ab_driver
  import seq_ab_pkg::*;
#(
  parameter int DELAY   = 3,
  parameter int MIN_GAP = 1,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic [CNT_W-1:0] pending,
  output logic             inflight,
  output logic             busy
);

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CNT_W-1:0] c_pend_max = '1;
  localparam logic [GAP_W-1:0] c_gap_load = GAP_W'(MIN_GAP - 1);

  generate
    if (DELAY < 1 || DELAY > DELAY_MAX || MIN_GAP < 1) begin : g_bad_param
      $error("seq_ab_driver: DELAY must be 1..%0d and MIN_GAP >= 1", DELAY_MAX);
    end
  endgenerate

  seq_ab_state_t    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_pending, w_pending_nxt;
  logic [GAP_W-1:0] r_gap;
  logic             r_a;
  logic             w_accept, w_issue, w_inflight, w_dl_any;

  assign req_ready = (r_pending != c_pend_max);
  // abort swallows both a same-cycle accept and a same-cycle issue.
  assign w_accept  = req_valid && req_ready && !abort;
  assign w_issue   = (r_state == ISSUE) && (r_gap == '0) && (r_pending != '0) && !abort;

  always_comb begin
    w_pending_nxt = r_pending;
    if (abort)                     w_pending_nxt = '0;
    else if (w_accept && !w_issue) w_pending_nxt = r_pending + 1'b1;
    else if (!w_accept && w_issue) w_pending_nxt = r_pending - 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_pending != '0) w_state_nxt = ISSUE;
      ISSUE:   if (w_pending_nxt == '0) w_state_nxt = (w_issue || w_inflight) ? DRAIN : IDLE;
      DRAIN: begin
        if (r_pending != '0)  w_state_nxt = ISSUE;
        else if (!w_inflight) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = w_inflight ? DRAIN : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_gap     <= '0;
      r_a       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_a       <= w_issue;
      if (w_issue)            r_gap <= c_gap_load;
      else if (r_gap != '0)   r_gap <= r_gap - 1'b1;
    end
  end

  seq_delay_line #(
    .DEPTH(DELAY)
  ) u_delay_line (
    .clk    (clk),
    .rst    (rst),
    .d_in   (r_a),
    .d_out  (b),
    .any_set(w_dl_any)
  );

  assign w_inflight = w_dl_any || r_a;
  assign a          = r_a;
  assign pending    = r_pending;
  assign inflight   = w_inflight;
  assign busy       = (r_pending != '0) || w_inflight;

endmodule

`default_nettype wire

// File: tb/tb_seq_ab_driver.sv
// ============================================================================
// Module   : tb_seq_ab_driver
// Purpose  : scoreboard bench driving two drivers (MIN_GAP 1 and 3) with shared stimulus
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_ab_driver;

  localparam int c_delay = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       abort = 1'b0;
  logic       ready_w[2], a_w[2], b_w[2], inflight_w[2], busy_w[2];
  logic [3:0] pend_w[2];
  bit         saw_full[2];

  int n_chk  = 0;
  int n_pass = 0;

  always #2 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int G = (gi == 0) ? 1 : 3;

    seq_ab_driver #(
      .DELAY(c_delay), .MIN_GAP(G), .CNT_W(4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(ready_w[gi]),
      .abort    (abort),
      .a        (a_w[gi]),
      .b        (b_w[gi]),
      .pending  (pend_w[gi]),
      .inflight (inflight_w[gi]),
      .busy     (busy_w[gi])
    );

    // Reference: queue of accepted-not-issued requests, queue of scheduled b times.
    int pq_t[$];
    bit pq_cold[$];
    int bq[$];
    int cyc    = 0;
    int last_a = -1000;
    int t_acc, lo, hi, dl;
    bit cold, s_v, s_r, s_ab, s_rst;

    always @(posedge clk) begin
      s_v = req_valid; s_r = ready_w[gi]; s_ab = abort; s_rst = rst;
      cyc++;
      #1;
      if (s_rst || rst) begin
        pq_t.delete(); pq_cold.delete(); bq.delete(); last_a = -1000;
        chk($sformatf("rst_a[%0d]", gi), int'(a_w[gi]), 0);
        chk($sformatf("rst_b[%0d]", gi), int'(b_w[gi]), 0);
        chk($sformatf("rst_pending[%0d]", gi), int'(pend_w[gi]), 0);
        chk($sformatf("rst_busy[%0d]", gi), int'(busy_w[gi]), 0);
        chk($sformatf("rst_ready[%0d]", gi), int'(ready_w[gi]), 1);
      end else begin
        if (s_ab) begin pq_t.delete(); pq_cold.delete(); end
        if (a_w[gi]) begin
          if (pq_t.size() == 0) begin
            chk($sformatf("a_unexpected[%0d] cyc=%0d", gi, cyc), 1, 0);
          end else begin
            t_acc = pq_t.pop_front();
            cold  = pq_cold.pop_front();
            lo = imax(last_a + G, t_acc + (cold ? 2 : 1));
            hi = imax(t_acc + 2, last_a + G);
            chk($sformatf("a_time[%0d] cyc=%0d lo=%0d hi=%0d", gi, cyc, lo, hi),
                int'(cyc >= lo && cyc <= hi), 1);
          end
          last_a = cyc;
          bq.push_back(cyc + c_delay);
        end else if (pq_t.size() != 0) begin
          dl = imax(pq_t[0] + 2, last_a + G);
          if (cyc >= dl) begin
            chk($sformatf("a_missing[%0d] cyc=%0d due=%0d", gi, cyc, dl), 0, 1);
            void'(pq_t.pop_front()); void'(pq_cold.pop_front());
          end
        end
        if (bq.size() != 0 && bq[0] == cyc) begin
          chk($sformatf("b_on_time[%0d] cyc=%0d", gi, cyc), int'(b_w[gi]), 1);
          void'(bq.pop_front());
        end else begin
          chk($sformatf("b_unexpected[%0d] cyc=%0d", gi, cyc), int'(b_w[gi]), 0);
        end
        if (s_v && s_r && !s_ab) begin
          pq_cold.push_back(pq_t.size() == 0 && !a_w[gi]);
          pq_t.push_back(cyc);
        end
        chk($sformatf("pending[%0d]", gi), int'(pend_w[gi]), pq_t.size());
        chk($sformatf("ready[%0d]", gi), int'(ready_w[gi]), int'(pq_t.size() != 15));
        chk($sformatf("inflight[%0d]", gi), int'(inflight_w[gi]), int'(bq.size() != 0));
        chk($sformatf("busy[%0d]", gi), int'(busy_w[gi]), int'(pq_t.size() != 0 || bq.size() != 0));
        if (!ready_w[gi]) saw_full[gi] = 1'b1;
      end
    end

    ap_a_b: assert property (@(posedge clk) disable iff (rst) a_w[gi] |-> ##c_delay b_w[gi])
      else $error("FAIL ap_a_b[%0d] at %0t", gi, $time);
    ap_b_a: assert property (@(posedge clk) disable iff (rst) b_w[gi] |-> $past(a_w[gi], c_delay))
      else $error("FAIL ap_b_a[%0d] at %0t", gi, $time);
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy_w[0] || busy_w[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy_w[0] || busy_w[1]), 0);
  endtask

  task automatic burst(input int n);
    req_valid = 1'b1;
    repeat (n) @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single request accepted at the 10 ns edge.
    burst(1);
    #8;
    for (int i = 0; i < 2; i++) chk($sformatf("t1_a_high[%0d]", i), int'(a_w[i]), 1);
    #4;
    for (int i = 0; i < 2; i++) chk($sformatf("t1_a_low[%0d]", i), int'(a_w[i]), 0);
    #8;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t1_b_high[%0d]", i), int'(b_w[i]), 1);
      chk($sformatf("t1_busy_low[%0d]", i), int'(busy_w[i]), 0);
    end
    @(negedge clk);

    // Five back-to-back, then a long hold that fills the MIN_GAP=3 instance.
    burst(5);
    wait_idle();
    burst(30);
    wait_idle();

    // Three requests: spacing on the gap instance is fixed by MIN_GAP.
    burst(3);
    wait_idle();

    // Abort during a burst, with a same-cycle request that must be dropped.
    req_valid = 1'b1;
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) chk($sformatf("abort_pending[%0d]", i), int'(pend_w[i]), 0);
    wait_idle();

    // Asynchronous reset with transactions in flight.
    burst(3);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1.5 rst = 1'b1;
    #0.3;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst_a[%0d]", i), int'(a_w[i]), 0);
      chk($sformatf("arst_b[%0d]", i), int'(b_w[i]), 0);
      chk($sformatf("arst_pending[%0d]", i), int'(pend_w[i]), 0);
      chk($sformatf("arst_busy[%0d]", i), int'(busy_w[i]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    burst(1);
    wait_idle();

    // Randomized traffic with occasional aborts.
    repeat (400) begin
      req_valid = ($urandom_range(0, 99) < 60);
      abort     = ($urandom_range(0, 99) < 3);
      @(negedge clk);
    end
    req_valid = 1'b0;
    abort     = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    chk("full_seen_gap3", int'(saw_full[1]), 1);
    chk("left_pending0", g_dut[0].pq_t.size() + g_dut[0].bq.size(), 0);
    chk("left_pending1", g_dut[1].pq_t.size() + g_dut[1].bq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
